cond_flag_unit: RTL
===================

Name: cond_flag_unit

Overview:
- Parametrised successor to the combinational condition/overflow evaluator.
- Holds registered N/Z/V/C flag sets for NCTX independent contexts, updated from ALU results.
- Evaluates 4-bit condition codes against a selected context through a valid/ready request port and a 1-entry registered response buffer.
- Sits between the ALU writeback and the branch/predication logic of the core.

Parameters:
WIDTH, 32, ALU result width in bits (>=2).
NCTX, 2, number of independent flag contexts (>=1); CW = max(1, clog2(NCTX)).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result present this cycle
alu_setflags  in  1  result updates flags (ignored when alu_valid=0)
alu_ctx  in  CW  context written
alu_is_sum  in  1  1=add/sub (updates V,C), 0=logic op (V,C preserved)
alu_sub  in  1  1=subtract (B inverted for overflow)
alu_a_msb  in  1  operand A MSB
alu_b_msb  in  1  operand B MSB (pre-inversion)
alu_carry  in  1  adder carry-out
alu_res  in  WIDTH  ALU result
alu_vout  out  1  combinational overflow of current ALU op (0 unless alu_is_sum)
cond_valid  in  1  evaluation request
cond_ready  out  1  request accepted when valid&ready
cond_code  in  4  condition code
cond_ctx  in  CW  context to test
res_valid  out  1  response held
res_ready  in  1  consumer accepts response
res_taken  out  1  condition result
flags_out  out  4*NCTX  {N,Z,V,C} per context, ctx0 in LSBs

Behaviour:
- Reset: all flags 0, res_valid=0, res_taken=0. Reset overrides any same-cycle update or request.
- Flag write when alu_valid & alu_setflags, with alu_ctx < NCTX (out-of-range ctx ignored):
  - N = alu_res[WIDTH-1]
  - Z = (alu_res == 0)
  - If alu_is_sum: beff = alu_b_msb ^ alu_sub; V = (alu_a_msb == beff) & (alu_res[WIDTH-1] != alu_a_msb); C = alu_carry.
  - Else V, C unchanged.
  - Visible in flags_out the next cycle.
- alu_vout = alu_is_sum & V as computed above. Combinational, independent of alu_valid gating.
- Condition codes (N,Z,V,C of cond_ctx):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
  - Out-of-range cond_ctx evaluates with all-zero flags.
- Handshake:
  - cond_ready = !res_valid | res_ready (further gated per Optional Feature).
  - On accept: res_taken registered, res_valid=1 next cycle. Latency 1 cycle.
  - res_valid clears on res_ready when no new accept that cycle.
  - Simultaneous res_ready and accept: buffer reloads, res_valid stays 1.
  - res_taken and res_valid are stable while res_valid & !res_ready.
- Same-cycle hazard: alu write to ctx X and request on ctx X in the same cycle. Handling depends on the Optional Feature.
- Requests and writes to different contexts never interact.

Optional Feature:
COND_BYPASS_EN:
- Defined: a same-ctx same-cycle write is forwarded; evaluation uses the new flags. cond_ready is not affected by the ALU port.
- Undefined: cond_ready is additionally forced 0 when alu_valid & alu_setflags & (alu_ctx == cond_ctx). The request is accepted the next cycle against the updated registered flags. Adds no storage.

Test Plan:
- Reset, then add 0x7FFFFFFF+0x00000001 (a_msb=0, b_msb=0, carry=0, res=0x80000000) ctx0 -> flags_out[3:0]=4'b1010 (N=1, V=1); alu_vout=1.
- Sub res=0, carry=1 ctx1; then requests EQ, HI, GE on ctx1 -> res_taken 1, 0, 1, each 1 cycle after accept.
- Logic op res=0 ctx0 after V=1 -> Z=1, N=0, V stays 1; code 13 LE -> 1.
- Hold res_ready=0 with res_valid=1 for 3 cycles while cond_valid=1 -> cond_ready=0, res_taken stable. Then res_ready=1 and new accept in the same cycle -> res_valid stays 1 with new result.
- Same-cycle write Z=1 ctx0 plus EQ request ctx0:
  - With COND_BYPASS_EN: accepted, res_taken=1.
  - Without: cond_ready=0 that cycle, accepted next cycle, res_taken=1.
- Assert rst during a pending response and a flag write -> next cycle res_valid=0, flags_out=0.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Registered N/Z/V/C flag contexts with a valid/ready condition evaluator and 1-entry response buffer.
// Optional macro COND_BYPASS_EN: forward same-cycle same-context flag writes into evaluation.
module cond_flag_unit #(
  parameter int WIDTH = 32,
  parameter int NCTX  = 2,
  localparam int CW   = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic              alu_setflags,
  input  logic [CW-1:0]     alu_ctx,
  input  logic              alu_is_sum,
  input  logic              alu_sub,
  input  logic              alu_a_msb,
  input  logic              alu_b_msb,
  input  logic              alu_carry,
  input  logic [WIDTH-1:0]  alu_res,
  output logic              alu_vout,
  input  logic              cond_valid,
  output logic              cond_ready,
  input  logic [3:0]        cond_code,
  input  logic [CW-1:0]     cond_ctx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [4*NCTX-1:0] flags_out
);

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_e;

  logic [4*NCTX-1:0] flags_q, flags_d;
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;

  logic       res_msb, res_zero, beff, v_calc;
  logic       wr_en;
  logic [3:0] wr_old, wr_flags;
  logic [3:0] ev_flags;
  logic       ev_n, ev_z, ev_v, ev_c;
  logic       taken;
  logic       accept;
  cond_e      code;

  // ALU-side flag computation
  always_comb begin
    res_msb  = alu_res[WIDTH-1];
    res_zero = (alu_res == '0);
    beff     = alu_b_msb ^ alu_sub;
    v_calc   = (alu_a_msb == beff) & (res_msb != alu_a_msb);
    alu_vout = alu_is_sum & v_calc;
    wr_en    = alu_valid & alu_setflags & (32'(alu_ctx) < 32'(NCTX));
  end

  always_comb begin
    wr_old = '0;
    for (int unsigned i = 0; i < NCTX; i++) begin
      if (alu_ctx == CW'(i)) wr_old = flags_q[4*i +: 4];
    end
    wr_flags = {res_msb, res_zero,
                alu_is_sum ? v_calc    : wr_old[1],
                alu_is_sum ? alu_carry : wr_old[0]};
  end

  always_comb begin
    flags_d = flags_q;
    for (int unsigned i = 0; i < NCTX; i++) begin
      if (wr_en && (alu_ctx == CW'(i))) flags_d[4*i +: 4] = wr_flags;
    end
  end

  // Evaluation flags: out-of-range context reads as all-zero
  always_comb begin
    ev_flags = '0;
    for (int unsigned i = 0; i < NCTX; i++) begin
      if (cond_ctx == CW'(i)) ev_flags = flags_q[4*i +: 4];
    end
`ifdef COND_BYPASS_EN
    if (wr_en && (alu_ctx == cond_ctx)) ev_flags = wr_flags;
`endif
    {ev_n, ev_z, ev_v, ev_c} = ev_flags;
  end

  always_comb begin
    code  = cond_e'(cond_code);
    taken = 1'b0;
    case (code)
      CC_EQ: taken = ev_z;
      CC_NE: taken = !ev_z;
      CC_CS: taken = ev_c;
      CC_CC: taken = !ev_c;
      CC_MI: taken = ev_n;
      CC_PL: taken = !ev_n;
      CC_VS: taken = ev_v;
      CC_VC: taken = !ev_v;
      CC_HI: taken = ev_c & !ev_z;
      CC_LS: taken = !ev_c | ev_z;
      CC_GE: taken = (ev_n == ev_v);
      CC_LT: taken = (ev_n != ev_v);
      CC_GT: taken = !ev_z & (ev_n == ev_v);
      CC_LE: taken = ev_z | (ev_n != ev_v);
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  // Without forwarding, a same-context write stalls the request one cycle
  always_comb begin
`ifdef COND_BYPASS_EN
    cond_ready = !res_valid_q | res_ready;
`else
    cond_ready = (!res_valid_q | res_ready) &
                 !(alu_valid & alu_setflags & (alu_ctx == cond_ctx));
`endif
    accept      = cond_valid & cond_ready;
    res_valid_d = accept ? 1'b1 : (res_ready ? 1'b0 : res_valid_q);
    res_taken_d = accept ? taken : res_taken_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign flags_out = flags_q;

endmodule
